// File: rtl/gpio_apb_pkg16.sv
// Shared definitions for the two-requester APB master arbiter in front of the GPIO slave.
// Holds the transfer FSM encoding and the default bus widths.
package gpio_apb_pkg16;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/gpio_rr_arb16.sv
// Two-way round-robin arbiter with a 1-bit last-grant pointer.
// The pointer only moves when grant_en is high and some request is present.
module gpio_rr_arb16 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant_en && (req != 2'b00)) begin
            last_d = grant[1];
        end
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/gpio_apb_arb16.sv
// Arbitrates two requesters onto a single APB master port to the GPIO slave.
// One transfer in flight at a time: IDLE -> SETUP -> ACCESS -> DONE.
module gpio_apb_arb16
    import gpio_apb_pkg16::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                pclk16,
    input  logic                p_reset16,
    input  logic [1:0]          req_valid16,
    input  logic [1:0]          req_write16,
    input  logic [2*ADDR_W-1:0] req_addr16,
    input  logic [2*DATA_W-1:0] req_wdata16,
    output logic [1:0]          req_done16,
    output logic [DATA_W-1:0]   req_rdata16,
    output logic                psel16,
    output logic                penable16,
    output logic                pwrite16,
    output logic [ADDR_W-1:0]   paddr16,
    output logic [DATA_W-1:0]   pwdata16,
    input  logic [DATA_W-1:0]   prdata16
);

    apb_state_e        state_q, state_d;
    logic              grant_q, grant_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        grant;
    logic              take;

    gpio_rr_arb16 u_arb (
        .clk      (pclk16),
        .rst      (p_reset16),
        .req      (req_valid16),
        .grant_en (state_q == ST_IDLE),
        .grant    (grant)
    );

    assign take = (state_q == ST_IDLE) && (req_valid16 != 2'b00);

    always_ff @(posedge pclk16 or posedge p_reset16) begin
        if (p_reset16) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (take) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        psel16     = 1'b0;
        penable16  = 1'b0;
        req_done16 = 2'b00;
        case (state_q)
            ST_SETUP:  psel16 = 1'b1;
            ST_ACCESS: begin
                psel16    = 1'b1;
                penable16 = 1'b1;
            end
            ST_DONE:   req_done16 = grant_q ? 2'b10 : 2'b01;
            default:   ;
        endcase
    end

    // Request fields are captured only at grant, so later input changes cannot disturb the transfer.
    always_comb begin
        grant_d = grant_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (take) begin
            grant_d = grant[1];
            write_d = grant[1] ? req_write16[1] : req_write16[0];
            addr_d  = grant[1] ? req_addr16[2*ADDR_W-1:ADDR_W] : req_addr16[ADDR_W-1:0];
            wdata_d = grant[1] ? req_wdata16[2*DATA_W-1:DATA_W] : req_wdata16[DATA_W-1:0];
        end
        if (state_q == ST_ACCESS) begin
            rdata_d = prdata16;
        end
    end

    always_ff @(posedge pclk16 or posedge p_reset16) begin
        if (p_reset16) begin
            grant_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            grant_q <= grant_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign pwrite16    = write_q;
    assign paddr16     = addr_q;
    assign pwdata16    = wdata_q;
    assign req_rdata16 = rdata_q;

endmodule

// File: tb/tb_gpio_apb_arb16.sv
// Directed bench for gpio_apb_arb16: single transfers, round-robin ordering,
// input changes mid-transfer and reset abort, all with hand-computed expectations.
module tb_gpio_apb_arb16;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic                pclk16;
    logic                p_reset16;
    logic [1:0]          req_valid16;
    logic [1:0]          req_write16;
    logic [2*ADDR_W-1:0] req_addr16;
    logic [2*DATA_W-1:0] req_wdata16;
    logic [1:0]          req_done16;
    logic [DATA_W-1:0]   req_rdata16;
    logic                psel16;
    logic                penable16;
    logic                pwrite16;
    logic [ADDR_W-1:0]   paddr16;
    logic [DATA_W-1:0]   pwdata16;
    logic [DATA_W-1:0]   prdata16;

    int unsigned errors = 0;
    int unsigned checks = 0;

    gpio_apb_arb16 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .pclk16      (pclk16),
        .p_reset16   (p_reset16),
        .req_valid16 (req_valid16),
        .req_write16 (req_write16),
        .req_addr16  (req_addr16),
        .req_wdata16 (req_wdata16),
        .req_done16  (req_done16),
        .req_rdata16 (req_rdata16),
        .psel16      (psel16),
        .penable16   (penable16),
        .pwrite16    (pwrite16),
        .paddr16     (paddr16),
        .pwdata16    (pwdata16),
        .prdata16    (prdata16)
    );

    initial pclk16 = 1'b0;
    always #5 pclk16 = ~pclk16;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int unsigned r, input logic wr,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_write16[r] = wr;
        if (r == 0) begin
            req_addr16[ADDR_W-1:0]  = a;
            req_wdata16[DATA_W-1:0] = d;
        end else begin
            req_addr16[2*ADDR_W-1:ADDR_W]  = a;
            req_wdata16[2*DATA_W-1:DATA_W] = d;
        end
    endtask

    initial begin
        int unsigned cyc;
        logic [1:0] exp_g;

        p_reset16   = 1'b1;
        req_valid16 = 2'b00;
        req_write16 = 2'b00;
        req_addr16  = '0;
        req_wdata16 = '0;
        prdata16    = 32'h1234_5678;
        repeat (2) @(negedge pclk16);

        check("rst_psel",    {63'd0, psel16},    64'd0);
        check("rst_penable", {63'd0, penable16}, 64'd0);
        check("rst_pwrite",  {63'd0, pwrite16},  64'd0);
        check("rst_done",    {62'd0, req_done16}, 64'd0);
        check("rst_paddr",   {58'd0, paddr16},   64'd0);
        check("rst_pwdata",  {32'd0, pwdata16},  64'd0);
        check("rst_rdata",   {32'd0, req_rdata16}, 64'd0);
        p_reset16 = 1'b0;
        @(negedge pclk16);

        // Requester 0 write 0x04 <- 0xFF
        set_req(0, 1'b1, 6'h04, 32'h0000_00FF);
        req_valid16 = 2'b01;
        @(negedge pclk16);
        check("w_setup_psel",    {63'd0, psel16},    64'd1);
        check("w_setup_penable", {63'd0, penable16}, 64'd0);
        check("w_setup_paddr",   {58'd0, paddr16},   64'h04);
        check("w_setup_pwrite",  {63'd0, pwrite16},  64'd1);
        check("w_setup_pwdata",  {32'd0, pwdata16},  64'hFF);
        check("w_setup_done",    {62'd0, req_done16}, 64'd0);
        @(negedge pclk16);
        check("w_access_psel",    {63'd0, psel16},    64'd1);
        check("w_access_penable", {63'd0, penable16}, 64'd1);
        check("w_access_paddr",   {58'd0, paddr16},   64'h04);
        @(negedge pclk16);
        check("w_done",      {62'd0, req_done16}, 64'b01);
        check("w_done_psel", {63'd0, psel16},     64'd0);
        req_valid16 = 2'b00;
        @(negedge pclk16);
        check("w_idle_done",  {62'd0, req_done16}, 64'd0);
        check("w_idle_paddr", {58'd0, paddr16},    64'h04);

        // Requester 1 read 0x08, slave returns 0xDEADBEEF
        set_req(1, 1'b0, 6'h08, 32'h0);
        prdata16    = 32'hDEAD_BEEF;
        req_valid16 = 2'b10;
        @(negedge pclk16);
        check("r_setup_paddr",  {58'd0, paddr16},  64'h08);
        check("r_setup_pwrite", {63'd0, pwrite16}, 64'd0);
        @(negedge pclk16);
        check("r_access_penable", {63'd0, penable16}, 64'd1);
        @(negedge pclk16);
        check("r_done",  {62'd0, req_done16},  64'b10);
        check("r_rdata", {32'd0, req_rdata16}, 64'hDEAD_BEEF);
        req_valid16 = 2'b00;
        prdata16    = 32'h0BAD_F00D;
        repeat (2) @(negedge pclk16);
        check("r_rdata_hold", {32'd0, req_rdata16}, 64'hDEAD_BEEF);

        // Both requesters valid: last grant was 1, so order 0,1,0,1 every 4 cycles
        set_req(0, 1'b1, 6'h0C, 32'hAAAA_0000);
        set_req(1, 1'b1, 6'h14, 32'h0000_5555);
        req_valid16 = 2'b11;
        for (int t = 0; t < 4; t++) begin
            cyc = 0;
            do begin
                @(negedge pclk16);
                cyc++;
            end while (req_done16 == 2'b00 && cyc < 10);
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            check($sformatf("rr_grant%0d", t), {62'd0, req_done16}, {62'd0, exp_g});
            check($sformatf("rr_cycles%0d", t), 64'(cyc), (t == 0) ? 64'd3 : 64'd4);
            check($sformatf("rr_paddr%0d", t), {58'd0, paddr16},
                  (t % 2 == 0) ? 64'h0C : 64'h14);
        end
        req_valid16 = 2'b00;
        @(negedge pclk16);

        // Address change during ACCESS must not reach the bus
        set_req(0, 1'b0, 6'h04, 32'h0);
        req_valid16 = 2'b01;
        @(negedge pclk16);
        check("hold_setup_paddr", {58'd0, paddr16}, 64'h04);
        @(negedge pclk16);
        set_req(0, 1'b1, 6'h10, 32'hFFFF_FFFF);
        #1;
        check("hold_access_paddr",  {58'd0, paddr16},  64'h04);
        check("hold_access_pwrite", {63'd0, pwrite16}, 64'd0);
        @(negedge pclk16);
        check("hold_done",       {62'd0, req_done16}, 64'b01);
        check("hold_done_paddr", {58'd0, paddr16},    64'h04);
        req_valid16 = 2'b00;
        @(negedge pclk16);

        // Reset during ACCESS: last grant was 0, reset must restore pointer to 1
        set_req(0, 1'b0, 6'h20, 32'h0);
        req_valid16 = 2'b01;
        @(negedge pclk16);
        @(negedge pclk16);
        check("abort_in_access", {63'd0, penable16}, 64'd1);
        p_reset16 = 1'b1;
        #1;
        check("abort_psel",    {63'd0, psel16},     64'd0);
        check("abort_penable", {63'd0, penable16},  64'd0);
        check("abort_rdata",   {32'd0, req_rdata16}, 64'd0);
        req_valid16 = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk16);
            check($sformatf("abort_nodone%0d", i), {62'd0, req_done16}, 64'd0);
        end
        p_reset16 = 1'b0;
        @(negedge pclk16);
        check("post_rst_nodone", {62'd0, req_done16}, 64'd0);
        set_req(0, 1'b0, 6'h01, 32'h0);
        set_req(1, 1'b0, 6'h02, 32'h0);
        req_valid16 = 2'b11;
        cyc = 0;
        do begin
            @(negedge pclk16);
            cyc++;
        end while (req_done16 == 2'b00 && cyc < 10);
        check("post_rst_tie",    {62'd0, req_done16}, 64'b01);
        check("post_rst_cycles", 64'(cyc), 64'd3);
        req_valid16 = 2'b00;
        @(negedge pclk16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_apb_arb16.md
GPIO_APB_ARB16 -- requirements
Module: gpio_apb_arb16

Interface
REQ-001 Parameters, one per line: ADDR_W, 6, APB address width; DATA_W, 32, APB data width.
REQ-002 Clocking is fixed: one clock; reset is asynchronous and active-high.
REQ-003 pclk16  input  1  APB clock; all state changes on its rising edge.
REQ-004 p_reset16  input  1  asynchronous, active-high reset.
REQ-005 req_valid16  input  2  per-requester transfer request; requester holds it until that requester's done pulse.
REQ-006 req_write16  input  2  per-requester direction; 1 = write.
REQ-007 req_addr16  input  2*ADDR_W  per-requester address; requester 0 occupies the low slice.
REQ-008 req_wdata16  input  2*DATA_W  per-requester write data.
REQ-009 req_done16  output  2  one-cycle pulse marking completion for a requester.
REQ-010 req_rdata16  output  DATA_W  read data, valid while a req_done16 bit is high.
REQ-011 psel16, penable16, pwrite16  output  1 each  APB master controls to the GPIO slave.
REQ-012 paddr16  output  ADDR_W  APB address; pwdata16  output  DATA_W  APB write data.
REQ-013 prdata16  input  DATA_W  APB read data from the GPIO slave.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, ACCESS and DONE; exactly one APB transfer is in flight at a time.
REQ-015 IDLE: with any req_valid16 bit set, the arbiter SHALL grant one requester, latch its write/addr/wdata and go to SETUP; otherwise it SHALL stay in IDLE.
REQ-016 SETUP: psel16=1 and penable16=0; the FSM SHALL go to ACCESS unconditionally.
REQ-017 ACCESS: psel16=1 and penable16=1; the block SHALL capture prdata16 into req_rdata16 and go to DONE.
REQ-018 DONE: req_done16[grant]=1 for exactly one cycle; the FSM SHALL return to IDLE.
REQ-019 Latency: with req_valid16 sampled in IDLE at edge N, SETUP is at N+1, ACCESS at N+2 and the done pulse at N+3; back-to-back transfers occur every 4 cycles.
REQ-020 Arbitration SHALL be round-robin with a 1-bit last-grant pointer; when both requesters are valid, the one not granted last wins.
REQ-021 A single valid requester SHALL be granted regardless of the pointer; the pointer SHALL update only on grant.
REQ-022 paddr16, pwrite16 and pwdata16 SHALL hold the latched values from SETUP through ACCESS, and SHALL hold the last latched values in IDLE and DONE.
REQ-023 req_rdata16 SHALL hold its value until the next ACCESS; for writes it is don't-care but still holds the captured prdata16.
REQ-024 Changes on req_* inputs after grant SHALL NOT affect the transfer in flight.
REQ-025 A requester's req_valid16 still high in the cycle after its done pulse is treated as a new request.

Reset
REQ-026 While p_reset16 is high: FSM=IDLE; psel16, penable16, pwrite16 and req_done16 = 0; paddr16, pwdata16 and req_rdata16 = 0; last-grant pointer = 1, so requester 0 wins the first tie.
REQ-027 Reset asserted mid-transfer SHALL drop psel16 and penable16 asynchronously; no done pulse is issued for the aborted transfer.

Structure
REQ-028 Shared package gpio_apb_pkg16 SHALL hold the FSM state encoding (2 bits) and the ADDR_W/DATA_W defaults.
REQ-029 Round-robin grant logic SHALL be one sub-module, gpio_rr_arb16 (2 requests, pointer, grant one-hot).

Verification
REQ-030 Requester 0 writes addr 0x04, data 0x0000_00FF -> SETUP then ACCESS with paddr16=0x04, pwrite16=1; req_done16=2'b01 three cycles after request.
REQ-031 Requester 1 reads 0x08 with the slave returning 0xDEAD_BEEF -> req_rdata16=0xDEAD_BEEF while req_done16=2'b10.
REQ-032 Both requesters held valid for 4 transfers -> grant order 0,1,0,1; each transfer takes 4 cycles.
REQ-033 Requester 0 changes addr from 0x04 to 0x10 during ACCESS -> paddr16 stays 0x04 until DONE.
REQ-034 p_reset16 pulsed during ACCESS -> psel16=0 immediately; no done pulse; next request after reset is granted to requester 0 on a tie.
